// File: rtl/stack_datapath.sv
// stack_datapath: LIFO storage and stack pointer for the 8Queen stack.
// Takes push/pop/clear strobes from the stack controller, returns full (msb)
// and empty (zero) status, and keeps a registered copy of the top entry.
// Optional build macro STACK_PEEK_EN adds a combinational random-access read
// port (peek_idx -> peek_data) so the solver can scan every placed queen.
module stack_datapath #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef STACK_PEEK_EN
  input  logic [ADDR_WIDTH-1:0] peek_idx,
  output logic [DATA_WIDTH-1:0] peek_data,
`endif
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [ADDR_WIDTH:0]   sp,
  output logic                  msb,
  output logic                  zero
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] SP_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] SP_TWO = SP_ONE + SP_ONE;

  // Storage is deliberately not reset; entries above sp are don't-care.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   sp_q;
  logic [DATA_WIDTH-1:0] top_q;

  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;
  logic                  do_replace;
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   sp_dec1;
  logic [ADDR_WIDTH:0]   sp_dec2;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] pop_reload;

  // Status flags decode straight off the pointer register, no added latency.
  assign full  = sp_q[ADDR_WIDTH];
  assign empty = (sp_q == '0);

  assign sp       = sp_q;
  assign msb      = full;
  assign zero     = empty;
  assign top_data = top_q;

  // Decode strobes by priority: clear, then push&pop, then push, then pop.
  // push&pop on an empty stack degrades to a plain push; on a non-empty
  // stack (even a full one) it rewrites the top entry in place.
  always_comb begin
    do_replace = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    if (!clear) begin
      if (push && pop && !empty) begin
        do_replace = 1'b1;
      end else if (push) begin
        do_push = !full;
      end else if (pop) begin
        do_pop = !empty;
      end
    end
  end

  // Address arithmetic: pointer math is ADDR_WIDTH+1 bits; memory indices are
  // the low bits, which are in range whenever the guarded operation fires.
  always_comb begin
    sp_dec1    = sp_q - SP_ONE;
    sp_dec2    = sp_q - SP_TWO;
    wr_en      = do_push || do_replace;
    wr_addr    = do_replace ? sp_dec1[ADDR_WIDTH-1:0] : sp_q[ADDR_WIDTH-1:0];
    rd_addr    = sp_dec2[ADDR_WIDTH-1:0];
    pop_reload = (sp_q >= SP_TWO) ? mem[rd_addr] : '0;
  end

  // Synchronous write port; contents survive reset, clear and pop.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Pointer and cached top entry; asynchronous reset empties the stack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      top_q <= '0;
    end else if (clear) begin
      sp_q  <= '0;
      top_q <= '0;
    end else if (do_replace) begin
      top_q <= data_in;
    end else if (do_push) begin
      sp_q  <= sp_q + SP_ONE;
      top_q <= data_in;
    end else if (do_pop) begin
      sp_q  <= sp_dec1;
      top_q <= pop_reload;
    end
  end

`ifdef STACK_PEEK_EN
  // Random-access peek for conflict scanning; caller ignores idx >= sp.
  assign peek_data = mem[peek_idx];
`endif

endmodule

// File: tb/tb_stack_datapath.sv
// Directed self-checking bench for stack_datapath.
// Build with STACK_PEEK_EN defined to also exercise the peek read port.
module tb_stack_datapath;

  localparam int DATA_WIDTH = 3;
  localparam int ADDR_WIDTH = 3;

  logic                  clk;
  logic                  reset;
  logic                  push;
  logic                  pop;
  logic                  clear;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] top_data;
  logic [ADDR_WIDTH:0]   sp;
  logic                  msb;
  logic                  zero;
`ifdef STACK_PEEK_EN
  logic [ADDR_WIDTH-1:0] peek_idx;
  logic [DATA_WIDTH-1:0] peek_data;
`endif

  int n_tests;
  int n_fail;

  stack_datapath #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .data_in  (data_in),
`ifdef STACK_PEEK_EN
    .peek_idx (peek_idx),
    .peek_data(peek_data),
`endif
    .top_data (top_data),
    .sp       (sp),
    .msb      (msb),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one set of strobes across a single rising edge; called at a negedge,
  // returns at the next negedge with strobes released.
  task automatic op(input logic p, input logic q, input logic c, input logic [DATA_WIDTH-1:0] d);
    push    = p;
    pop     = q;
    clear   = c;
    data_in = d;
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic check_state(input string tag, input int exp_sp, input int exp_top);
    check({tag, ".sp"},   32'(sp),       32'(exp_sp));
    check({tag, ".top"},  32'(top_data), 32'(exp_top));
    check({tag, ".zero"}, 32'(zero),     32'(exp_sp == 0));
    check({tag, ".msb"},  32'(msb),      32'(exp_sp == 8));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    data_in = '0;
`ifdef STACK_PEEK_EN
    peek_idx = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_state("reset", 0, 0);

    // push 5,2,7 then pop down to empty
    op(1, 0, 0, 3'd5);
    op(1, 0, 0, 3'd2);
    op(1, 0, 0, 3'd7);
    check_state("push3", 3, 7);
    op(0, 1, 0, 3'd0);
    check_state("pop1", 2, 2);
    op(0, 1, 0, 3'd0);
    op(0, 1, 0, 3'd0);
    check_state("pop3", 0, 0);

    // asynchronous reset mid-operation, observed before any rising edge
    op(1, 0, 0, 3'd1);
    op(1, 0, 0, 3'd2);
    check_state("pre_rst", 2, 2);
    #2 reset = 1'b1;
    #1 check_state("async_rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    check_state("rst_hold", 0, 0);
    // first push after release lands in mem[0], seen via pop reload
    op(1, 0, 0, 3'd6);
    op(1, 0, 0, 3'd4);
    op(0, 1, 0, 3'd0);
    check_state("post_rst", 1, 6);
    op(0, 1, 0, 3'd0);
    check_state("post_rst_empty", 0, 0);

    // fill to full, overflow push ignored
    for (int i = 0; i < 8; i++) op(1, 0, 0, 3'(i));
    check_state("full", 8, 7);
    op(1, 0, 0, 3'd3);
    check_state("overflow", 8, 7);
    // replace on a full stack
    op(1, 1, 0, 3'd5);
    check_state("full_replace", 8, 5);
    // pop down; mem[0] must still hold 0 (overflow wrote nothing)
    for (int k = 1; k < 8; k++) begin
      op(0, 1, 0, 3'd0);
      check_state($sformatf("drain%0d", k), 8 - k, 7 - k);
    end
    op(0, 1, 0, 3'd0);
    check_state("drained", 0, 0);

    // underflow ignored, then push works
    op(0, 1, 0, 3'd0);
    check_state("underflow", 0, 0);
    op(1, 0, 0, 3'd4);
    check_state("push4", 1, 4);
    op(0, 1, 0, 3'd0);

    // replace top on [1,6]
    op(1, 0, 0, 3'd1);
    op(1, 0, 0, 3'd6);
    op(1, 1, 0, 3'd3);
    check_state("replace", 2, 3);
    op(0, 1, 0, 3'd0);
    check_state("replace_pop", 1, 1);
    // clear overrides a simultaneous push
    op(1, 0, 0, 3'd5);
    op(1, 0, 1, 3'd7);
    check_state("clear_push", 0, 0);
    // push&pop on empty acts as push
    op(1, 1, 0, 3'd4);
    check_state("pp_empty", 1, 4);
    op(1, 0, 0, 3'd2);
    op(0, 1, 0, 3'd0);
    check_state("pp_empty_pop", 1, 4);
    op(0, 0, 1, 3'd0);
    check_state("clear", 0, 0);

`ifdef STACK_PEEK_EN
    op(1, 0, 0, 3'd1);
    op(1, 0, 0, 3'd3);
    op(1, 0, 0, 3'd5);
    peek_idx = 3'd0;
    #1 check("peek0", 32'(peek_data), 32'd1);
    peek_idx = 3'd1;
    #1 check("peek1", 32'(peek_data), 32'd3);
    peek_idx = 3'd2;
    #1 check("peek2", 32'(peek_data), 32'd5);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
